// File: rtl/sha2_msg_sched.sv
// sha2_msg_sched: SHA-256 message schedule, buffers a 16-word block and streams W_0..W_{NumRound-1}
module sha2_msg_sched #(
    parameter int NumRound = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sha_en,
    input  logic        hash_start,
    input  logic        wipe_secret,
    input  logic [31:0] wipe_v,
    input  logic        shaf_rvalid,
    input  logic [31:0] shaf_rdata,
    output logic        shaf_rready,
    output logic        w_valid,
    output logic [31:0] w_data,
    output logic [5:0]  w_round,
    input  logic        w_ready,
    output logic        block_done
);
    localparam int BlkWords = 16;
    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;
    state_e      state, state_n;
    logic [31:0] w   [BlkWords];
    logic [31:0] w_n [BlkWords];
    logic [4:0]  ld_cnt, ld_n;
    logic [5:0]  rnd_cnt, rnd_n;
    logic        ld_acc, shift, last, wipe;
    logic [31:0] w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign shaf_rready = rst_ni && sha_en && !hash_start && state == StLoad;
    assign w_valid     = rst_ni && state == StRun;
    assign w_data      = w_valid ? w[0] : '0;
    assign w_round     = w_valid ? rnd_cnt : '0;
    assign ld_acc      = shaf_rready && shaf_rvalid;
    assign shift       = w_valid && w_ready && sha_en && !hash_start;
    assign last        = rnd_cnt == 6'(NumRound - 1);
    assign block_done  = shift && last;
    assign wipe        = wipe_secret && sha_en && !hash_start;
    assign w_new       = s1(w[14]) + w[9] + s0(w[1]) + w[0];

    always_comb begin
        state_n = state;
        ld_n    = ld_cnt;
        rnd_n   = rnd_cnt;
        case (state)
            StIdle: state_n = hash_start ? StLoad : StIdle;
            StLoad: if (ld_acc) begin
                ld_n    = (ld_cnt == 5'd15) ? '0 : ld_cnt + 5'd1;
                state_n = (ld_cnt == 5'd15) ? StRun : StLoad;
            end
            StRun: if (shift) begin
                rnd_n   = last ? '0 : rnd_cnt + 6'd1;
                state_n = last ? StLoad : StRun;
            end
            default: state_n = StIdle;
        endcase
        if (hash_start) begin
            state_n = StLoad;
            ld_n    = '0;
            rnd_n   = '0;
        end
        if (!sha_en) begin
            state_n = StIdle;
            ld_n    = '0;
            rnd_n   = '0;
        end
    end

    // wipe overrides any shift or load write to the buffer in the same cycle
    always_comb begin
        for (int i = 0; i < BlkWords - 1; i++) w_n[i] = shift ? w[i + 1] : w[i];
        w_n[BlkWords - 1] = shift ? w_new : w[BlkWords - 1];
        if (ld_acc) w_n[ld_cnt[3:0]] = shaf_rdata;
        if (wipe) for (int i = 0; i < BlkWords; i++) w_n[i] = wipe_v;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= StIdle;
            ld_cnt  <= '0;
            rnd_cnt <= '0;
            w       <= '{default: '0};
        end else begin
            state   <= state_n;
            ld_cnt  <= ld_n;
            rnd_cnt <= rnd_n;
            w       <= w_n;
        end
    end
endmodule

// File: doc/sha2_msg_sched.md
Name: sha2_msg_sched

Overview:
SHA-256 message-schedule stage. It sits directly downstream of the padding stage and consumes its padded 32-bit word stream (shaf_rvalid/shaf_rdata/shaf_rready). It buffers one 512-bit block as 16 words, then emits W_0..W_63 one per handshake to the compression round logic. It asserts block_done after the last word of each block.

Parameters:
NumRound, 64, number of W words emitted per block; legal values 16..64
BlkWords, 16, words per block; fixed, not overridable

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
sha_en  in  1  engine enable
hash_start  in  1  pulse; begins a new message
wipe_secret  in  1  pulse; overwrite the word buffer
wipe_v  in  32  wipe value
shaf_rvalid  in  1  padded word valid (from padding stage)
shaf_rdata  in  32  padded word, big-endian byte order
shaf_rready  out  1  word accepted when high with shaf_rvalid
w_valid  out  1  W_t valid
w_data  out  32  W_t
w_round  out  6  t, index of w_data
w_ready  in  1  round logic consumes W_t
block_done  out  1  one-cycle pulse: W_{NumRound-1} consumed

Behaviour:
- Reset (rst_ni low at a clock edge) sets: state StIdle, ld_cnt=0, rnd_cnt=0, buffer w[0..15]=0.
- Outputs held while in reset: shaf_rready=0, w_valid=0, w_data=0, w_round=0, block_done=0.
- Registers: buffer w[0..15] (32 bits each), ld_cnt[4:0], rnd_cnt[5:0], state.
- StIdle: shaf_rready=0, w_valid=0.
  - sha_en && hash_start -> StLoad.
- StLoad: shaf_rready=1.
  - On each accept, w[ld_cnt] <= shaf_rdata and ld_cnt++.
  - Accept with ld_cnt==15: ld_cnt <= 0, next state StRun.
- StRun: w_valid=1, w_data=w[0], w_round=rnd_cnt; shaf_rready=0.
  - First w_valid is asserted the cycle after the 16th accept.
  - On w_valid && w_ready, shift: w[i] <= w[i+1] for i=0..14, w[15] <= new.
  - new = s1(w[14]) + w[9] + s0(w[1]) + w[0], mod 2^32.
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - rnd_cnt++ on each handshake.
  - Handshake at rnd_cnt==NumRound-1: block_done=1 that cycle (combinational), rnd_cnt <= 0, next state StLoad (next block).
- Throughput: 16 load cycles + NumRound run cycles per block, no bubbles when both sides are always ready.
- Backpressure: w_data and w_round are stable while w_valid && !w_ready. Upstream stalls (shaf_rvalid low) hold ld_cnt.
- sha_en low in any state: next state StIdle, ld_cnt=0, rnd_cnt=0; buffer retained.
- hash_start with sha_en high in any state: next state StLoad, ld_cnt=0, rnd_cnt=0.
  - Any word presented that cycle is NOT accepted: shaf_rready is forced 0 when hash_start=1.
- wipe_secret: all w[i] <= wipe_v; state and counters unchanged.
  - If coincident with a shift or load write, wipe wins for the buffer; counters still advance.
- Priority, highest first: reset > !sha_en > hash_start > wipe_secret > normal operation.
- ld_cnt never exceeds 15; rnd_cnt never exceeds NumRound-1.
- Any illegal state encoding -> StIdle.

Test Plan:
- "abc" block: load 0x61626380, 14x 0x00000000, 0x00000018 with w_ready=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB; block_done pulses once with w_round=63.
- All-zero block -> all 64 W=0; exactly 80 cycles from first accept to block_done with continuous valid/ready; second block loads immediately after.
- Random w_ready and shaf_rvalid stalls on the "abc" block -> same W sequence as the no-stall run; w_data/w_round stable during every stall; no word dropped or duplicated.
- hash_start at w_round=20 -> w_valid drops the next cycle, shaf_rready=1 the cycle after; a fresh 16-word load then yields W0 equal to the first new word.
- wipe_secret (wipe_v=0xDEADBEEF) mid-load at ld_cnt=7 -> all buffer entries become 0xDEADBEEF; remaining 9 loads overwrite w[7..15]; W0=0xDEADBEEF.
- rst_ni low mid-run for 1 cycle -> all outputs 0, state StIdle; no activity until sha_en && hash_start.
